// File: rtl/mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_access_unit: IDLE/REQ/DONE load/store sequencer with ack timeout  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_access_unit #(
  parameter int TIMEOUT = 15,
  parameter int WIDTH   = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] AluResult,
  input  logic [WIDTH-1:0] WriteData,
  input  logic             MemRead,
  input  logic             MemWrite,
  output logic             Stall,
  output logic [WIDTH-1:0] ReadData,
  output logic             BusError,
  output logic             MemReq,
  output logic             MemWe,
  output logic [WIDTH-1:0] MemAddr,
  output logic [WIDTH-1:0] MemWData,
  input  logic             MemAck,
  input  logic [WIDTH-1:0] MemRData
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic             berr_q, berr_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    berr_d  = berr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (MemRead || MemWrite) begin
          addr_d  = AluResult;
          wdata_d = WriteData;
          we_d    = MemWrite;
          req_d   = 1'b1;
          cnt_d   = 8'd0;
          state_d = REQ;
        end
      end
      REQ: begin
        // An ack on the timeout edge still counts as success.
        if (MemAck) begin
          req_d   = 1'b0;
          berr_d  = 1'b0;
          if (!we_q) rdata_d = MemRData;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == TIMEOUT_C - 8'd1) begin
            req_d   = 1'b0;
            rdata_d = '0;
            berr_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        berr_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      berr_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      berr_q  <= berr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Gated by rst so an abandoned access releases the pipeline immediately.
  assign Stall    = !rst && (((state_q == IDLE) && (MemRead || MemWrite)) || (state_q == REQ));
  assign ReadData = rdata_q;
  assign BusError = berr_q;
  assign MemReq   = req_q;
  assign MemWe    = we_q;
  assign MemAddr  = addr_q;
  assign MemWData = wdata_q;

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: TIMEOUT, 15, maximum number of REQ-state cycles to wait for MemAck before aborting (legal 1..255).
REQ-002 Parameter: WIDTH, 21, data and address width in bits.
REQ-003 Port: clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: AluResult  input  WIDTH  word address produced by the ALU.
REQ-006 Port: WriteData  input  WIDTH  store data (rt operand).
REQ-007 Port: MemRead  input  1  current instruction is a load.
REQ-008 Port: MemWrite  input  1  current instruction is a store.
REQ-009 Port: Stall  output  1  combinational; holds the PC and register-file write while high.
REQ-010 Port: ReadData  output  WIDTH  registered load result, valid in DONE.
REQ-011 Port: BusError  output  1  registered; high in DONE only when the access timed out.
REQ-012 Port: MemReq  output  1  registered request to external memory.
REQ-013 Port: MemWe  output  1  registered; 1 = write, 0 = read, meaningful while MemReq is high.
REQ-014 Port: MemAddr  output  WIDTH  registered copy of AluResult captured at acceptance.
REQ-015 Port: MemWData  output  WIDTH  registered copy of WriteData captured at acceptance.
REQ-016 Port: MemAck  input  1  memory completion, sampled only in REQ.
REQ-017 Port: MemRData  input  WIDTH  memory read data, sampled on the edge where MemAck is high in REQ.

Function
REQ-018 The FSM SHALL have three states: IDLE, REQ, DONE.
REQ-019 In IDLE with MemRead or MemWrite high, the next edge SHALL capture AluResult/WriteData into MemAddr/MemWData, set MemReq=1 and MemWe=MemWrite, clear the timeout counter, and enter REQ.
REQ-020 MemRead and MemWrite both high SHALL be treated as a write; no read occurs.
REQ-021 In REQ, MemAck high at an edge SHALL drop MemReq and enter DONE; for reads ReadData SHALL take MemRData; for writes ReadData SHALL hold its prior value.
REQ-022 In REQ, the timeout counter SHALL increment each cycle without MemAck; on the edge where it reaches TIMEOUT without MemAck, MemReq SHALL drop, ReadData SHALL become 0, BusError SHALL become 1, and the FSM SHALL enter DONE.
REQ-023 MemAck and timeout on the same edge SHALL resolve as a successful ack (BusError=0).
REQ-024 DONE SHALL last exactly one cycle, then return to IDLE; BusError SHALL clear on leaving DONE.
REQ-025 Stall SHALL be 1 in IDLE when MemRead or MemWrite is high, 1 throughout REQ, and 0 in DONE and in idle IDLE.
REQ-026 MemRead/MemWrite in DONE SHALL be ignored; a following memory instruction is accepted from IDLE on the next cycle.
REQ-027 MemAck in IDLE or DONE SHALL be ignored with no state or output change.
REQ-028 MemAddr, MemWData, MemWe SHALL hold stable from acceptance until leaving REQ.
REQ-029 Minimum latency: 3 cycles (IDLE-stall, REQ with MemAck, DONE) from instruction presentation to Stall low.

Reset
REQ-030 While rst is high, state SHALL be IDLE and MemReq, MemWe, MemAddr, MemWData, ReadData, BusError and the timeout counter SHALL be 0, immediately and independent of clk.
REQ-031 rst asserted in REQ SHALL drop MemReq without waiting for an edge and abandon the access; a late MemAck SHALL be ignored.

Verification
REQ-032 Load: MemRead=1, AluResult=0x00010, MemAck on 1st REQ cycle with MemRData=0x1ABCD -> MemAddr=0x00010, MemWe=0, Stall high 2 cycles, ReadData=0x1ABCD in DONE, BusError=0.
REQ-033 Store: MemWrite=1, AluResult=0x1FFFFF, WriteData=0x00055, MemAck after 3 REQ cycles -> MemWe=1, MemWData=0x00055, Stall high 4 cycles, ReadData unchanged.
REQ-034 Timeout: MemRead=1, TIMEOUT=15, MemAck held 0 -> MemReq high exactly 15 cycles, DONE with ReadData=0, BusError=1 for one cycle.
REQ-035 Simultaneous: MemRead=MemWrite=1 -> MemWe=1; MemAck on the 15th REQ cycle (same edge as timeout) -> BusError=0.
REQ-036 Reset mid-access: rst pulsed in 2nd REQ cycle -> MemReq=0 and Stall=0 asynchronously, FSM IDLE, later MemAck ignored.
REQ-037 Back-to-back loads: two consecutive load instructions -> two distinct REQ phases separated by DONE and one IDLE-stall cycle, each ReadData correct.
